vga_sync_gen: RTL and testbench

//   Pixel-timing generator. Consumes the 1-in-4 pixel-rate strobe from the pixel clock

---
 rtl/vga_pkg.sv | 23 ++
 rtl/vga_sync_gen_axis.sv | 74 +++++++
 rtl/vga_sync_gen.sv | 98 +++++++++
 tb/tb_vga_sync_gen.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared types and default 640x480@60 timing for the VGA sync generator.
package vga_pkg;

   typedef enum logic [1:0] {
      ST_ACTIVE,
      ST_FRONT,
      ST_SYNC,
      ST_BACK
   } axis_state_t;

   localparam int unsigned H_ACTIVE_DEF = 640;
   localparam int unsigned H_FP_DEF     = 16;
   localparam int unsigned H_SYNC_DEF   = 96;
   localparam int unsigned H_BP_DEF     = 48;
   localparam int unsigned V_ACTIVE_DEF = 480;
   localparam int unsigned V_FP_DEF     = 10;
   localparam int unsigned V_SYNC_DEF   = 2;
   localparam int unsigned V_BP_DEF     = 33;
   localparam bit          SYNC_POL_DEF = 1'b0;

   localparam int unsigned XY_W = 10;

endpackage

// File: rtl/vga_sync_gen_axis.sv
// One raster axis: position counter plus ACTIVE/FRONT/SYNC/BACK phase FSM.
// Next-cycle values are exported so the top can register outputs with no added latency.
module vga_axis_counter
   import vga_pkg::*;
#(
   parameter int unsigned ACTIVE = H_ACTIVE_DEF,
   parameter int unsigned FP     = H_FP_DEF,
   parameter int unsigned SYNC   = H_SYNC_DEF,
   parameter int unsigned BP     = H_BP_DEF,
   localparam int unsigned TOTAL = ACTIVE + FP + SYNC + BP,
   localparam int unsigned W     = $clog2(TOTAL)
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         step,
   output logic [W-1:0] pos_next_c,
   output axis_state_t  state_next_c,
   output logic         sync_next_c,
   output logic         wrap
);

   axis_state_t  state;
   logic [W-1:0] pos;
   logic [W-1:0] phase;
   logic [W-1:0] phase_next;
   logic [W-1:0] last_phase;

   // Reset parks the axis on the last BACK count so the first step wraps to 0.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= ST_BACK;
         pos   <= W'(TOTAL - 1);
         phase <= W'(BP - 1);
         wrap  <= 1'b1;
      end else begin
         state <= state_next_c;
         pos   <= pos_next_c;
         phase <= phase_next;
         wrap  <= (pos_next_c == W'(TOTAL - 1));
      end
   end

   always_comb begin
      state_next_c = state;
      pos_next_c   = pos;
      phase_next   = phase;
      last_phase   = W'(ACTIVE - 1);

      case (state)
         ST_ACTIVE: last_phase = W'(ACTIVE - 1);
         ST_FRONT:  last_phase = W'(FP - 1);
         ST_SYNC:   last_phase = W'(SYNC - 1);
         ST_BACK:   last_phase = W'(BP - 1);
      endcase

      if (step) begin
         pos_next_c = wrap ? '0 : pos + W'(1);
         if (phase == last_phase) begin
            phase_next = '0;
            case (state)
               ST_ACTIVE: state_next_c = ST_FRONT;
               ST_FRONT:  state_next_c = ST_SYNC;
               ST_SYNC:   state_next_c = ST_BACK;
               ST_BACK:   state_next_c = ST_ACTIVE;
            endcase
         end else begin
            phase_next = phase + W'(1);
         end
      end

      sync_next_c = (state_next_c == ST_SYNC);
   end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA pixel-timing generator: raster position, data-enable, syncs and start pulses,
// advancing on the pixel strobe in the system clock domain.
module vga_sync_gen
   import vga_pkg::*;
#(
   parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
   parameter int unsigned H_FP     = H_FP_DEF,
   parameter int unsigned H_SYNC   = H_SYNC_DEF,
   parameter int unsigned H_BP     = H_BP_DEF,
   parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
   parameter int unsigned V_FP     = V_FP_DEF,
   parameter int unsigned V_SYNC   = V_SYNC_DEF,
   parameter int unsigned V_BP     = V_BP_DEF,
   parameter bit          SYNC_POL = SYNC_POL_DEF
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            pclk,
   output logic            h_sync,
   output logic            v_sync,
   output logic            de,
   output logic [XY_W-1:0] x_pixel,
   output logic [XY_W-1:0] y_pixel,
   output logic            line_start,
   output logic            frame_start
);

   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int unsigned HW      = $clog2(H_TOTAL);
   localparam int unsigned VW      = $clog2(V_TOTAL);

   logic [HW-1:0] h_pos_next_c;
   logic [VW-1:0] v_pos_next_c;
   axis_state_t   h_state_next_c;
   axis_state_t   v_state_next_c;
   logic          h_sync_next_c;
   logic          v_sync_next_c;
   logic          h_wrap;
   logic          v_wrap;
   logic          v_step_c;
   logic          de_c;

   assign v_step_c = pclk & h_wrap;
   assign de_c     = (h_state_next_c == ST_ACTIVE) && (v_state_next_c == ST_ACTIVE);

   vga_axis_counter #(
      .ACTIVE (H_ACTIVE),
      .FP     (H_FP),
      .SYNC   (H_SYNC),
      .BP     (H_BP)
   ) u_h_axis (
      .clk          (clk),
      .reset        (reset),
      .step         (pclk),
      .pos_next_c   (h_pos_next_c),
      .state_next_c (h_state_next_c),
      .sync_next_c  (h_sync_next_c),
      .wrap         (h_wrap)
   );

   vga_axis_counter #(
      .ACTIVE (V_ACTIVE),
      .FP     (V_FP),
      .SYNC   (V_SYNC),
      .BP     (V_BP)
   ) u_v_axis (
      .clk          (clk),
      .reset        (reset),
      .step         (v_step_c),
      .pos_next_c   (v_pos_next_c),
      .state_next_c (v_state_next_c),
      .sync_next_c  (v_sync_next_c),
      .wrap         (v_wrap)
   );

   // Outputs follow the next counter values, so they move on the same edge as the counters.
   always_ff @(posedge clk) begin
      if (!reset) begin
         h_sync      <= ~SYNC_POL;
         v_sync      <= ~SYNC_POL;
         de          <= 1'b0;
         x_pixel     <= '0;
         y_pixel     <= '0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         h_sync      <= h_sync_next_c ? SYNC_POL : ~SYNC_POL;
         v_sync      <= v_sync_next_c ? SYNC_POL : ~SYNC_POL;
         de          <= de_c;
         x_pixel     <= de_c ? XY_W'(h_pos_next_c) : '0;
         y_pixel     <= de_c ? XY_W'(v_pos_next_c) : '0;
         line_start  <= pclk & h_wrap;
         frame_start <= pclk & h_wrap & v_wrap;
      end
   end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: full-size instance for line-level timing, a shrunken
// instance for frame-level timing.
module tb_vga_sync_gen;

   localparam int unsigned S_H_ACT = 8, S_H_FP = 2, S_H_SYN = 3, S_H_BP = 3;
   localparam int unsigned S_V_ACT = 4, S_V_FP = 1, S_V_SYN = 2, S_V_BP = 2;
   localparam int unsigned S_H_TOT = S_H_ACT + S_H_FP + S_H_SYN + S_H_BP;
   localparam int unsigned S_V_TOT = S_V_ACT + S_V_FP + S_V_SYN + S_V_BP;
   localparam int unsigned S_FRAME = S_H_TOT * S_V_TOT;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset_a, pclk_a, hs_a, vs_a, de_a, ls_a, fs_a;
   logic [9:0] x_a, y_a;
   logic       reset_b, pclk_b, hs_b, vs_b, de_b, ls_b, fs_b;
   logic [9:0] x_b, y_b;

   vga_sync_gen dut_a (
      .clk(clk), .reset(reset_a), .pclk(pclk_a), .h_sync(hs_a), .v_sync(vs_a),
      .de(de_a), .x_pixel(x_a), .y_pixel(y_a), .line_start(ls_a), .frame_start(fs_a)
   );

   vga_sync_gen #(
      .H_ACTIVE(S_H_ACT), .H_FP(S_H_FP), .H_SYNC(S_H_SYN), .H_BP(S_H_BP),
      .V_ACTIVE(S_V_ACT), .V_FP(S_V_FP), .V_SYNC(S_V_SYN), .V_BP(S_V_BP)
   ) dut_b (
      .clk(clk), .reset(reset_b), .pclk(pclk_b), .h_sync(hs_b), .v_sync(vs_b),
      .de(de_b), .x_pixel(x_b), .y_pixel(y_b), .line_start(ls_b), .frame_start(fs_b)
   );

   typedef struct {
      int   k;      // cumulative strobe count since reset release
      logic de;
      int   x;
      int   y;
      logic hs;
      logic vs;
      logic ls;
      logic fs;
   } vec_t;

   vec_t vecs[12];
   int   total = 0;
   int   bad   = 0;

   logic       c_de, c_hs, c_vs, c_ls, c_fs, c_ls2, c_fs2;
   logic [9:0] c_x, c_y;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // One strobe on the selected instance; outputs captured just after the strobe edge
   // and the pulses once more one clk later. Takes exactly 4 clk.
   task automatic strobe(input bit sel);
      @(negedge clk);
      if (sel) pclk_b = 1'b1; else pclk_a = 1'b1;
      @(posedge clk); #1;
      if (sel) begin
         c_de = de_b; c_x = x_b; c_y = y_b; c_hs = hs_b; c_vs = vs_b; c_ls = ls_b; c_fs = fs_b;
      end else begin
         c_de = de_a; c_x = x_a; c_y = y_a; c_hs = hs_a; c_vs = vs_a; c_ls = ls_a; c_fs = fs_a;
      end
      @(negedge clk);
      pclk_a = 1'b0;
      pclk_b = 1'b0;
      @(posedge clk); #1;
      c_ls2 = sel ? ls_b : ls_a;
      c_fs2 = sel ? fs_b : fs_a;
      repeat (2) @(posedge clk);
   endtask

   initial begin
      int   k;
      int   de_cnt, hs_cnt, hs_first, frozen_bad;
      logic pulse_leak;
      logic [23:0] snap;

      // position = k-1 strobes into the raster; h=(k-1)%800, v=(k-1)/800
      vecs[0]  = '{1,    1'b1, 0,   0, 1'b1, 1'b1, 1'b1, 1'b1};
      vecs[1]  = '{2,    1'b1, 1,   0, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[2]  = '{640,  1'b1, 639, 0, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[3]  = '{641,  1'b0, 0,   0, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[4]  = '{656,  1'b0, 0,   0, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[5]  = '{657,  1'b0, 0,   0, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[6]  = '{752,  1'b0, 0,   0, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[7]  = '{753,  1'b0, 0,   0, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[8]  = '{800,  1'b0, 0,   0, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[9]  = '{801,  1'b1, 0,   1, 1'b1, 1'b1, 1'b1, 1'b0};
      vecs[10] = '{802,  1'b1, 1,   1, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[11] = '{1101, 1'b1, 300, 1, 1'b1, 1'b1, 1'b0, 1'b0};

      reset_a = 1'b0; pclk_a = 1'b0;
      reset_b = 1'b0; pclk_b = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_a outputs", {25'd0, hs_a, vs_a, de_a, x_a == 10'd0, y_a == 10'd0, ls_a, fs_a},
            {25'd0, 7'b1101100});
      check("rst_b outputs", {25'd0, hs_b, vs_b, de_b, x_b == 10'd0, y_b == 10'd0, ls_b, fs_b},
            {25'd0, 7'b1101100});
      @(negedge clk);
      reset_a = 1'b1;
      reset_b = 1'b1;

      // Table-driven line walk on the full-size instance
      k = 0; de_cnt = 0; hs_cnt = 0; hs_first = -1; pulse_leak = 1'b0;
      for (int i = 0; i < 12; i++) begin
         while (k < vecs[i].k) begin
            strobe(1'b0);
            k++;
            if (k <= 800) begin
               if (c_de) de_cnt++;
               if (!c_hs) begin
                  hs_cnt++;
                  if (hs_first < 0) hs_first = k - 1;
               end
            end
            pulse_leak = pulse_leak | c_ls2 | c_fs2;
         end
         check($sformatf("row%0d de", i), 32'(c_de), 32'(vecs[i].de));
         check($sformatf("row%0d x", i),  32'(c_x),  vecs[i].x);
         check($sformatf("row%0d y", i),  32'(c_y),  vecs[i].y);
         check($sformatf("row%0d hs", i), 32'(c_hs), 32'(vecs[i].hs));
         check($sformatf("row%0d vs", i), 32'(c_vs), 32'(vecs[i].vs));
         check($sformatf("row%0d ls", i), 32'(c_ls), 32'(vecs[i].ls));
         check($sformatf("row%0d fs", i), 32'(c_fs), 32'(vecs[i].fs));
      end
      check("line de strobes", de_cnt, 640);
      check("line hsync strobes", hs_cnt, 96);
      check("hsync first h", hs_first, 656);
      check("pulse one clk only", 32'(pulse_leak), 0);

      // Hold pclk low at h=300: everything frozen, no pulses
      snap = {de_a, x_a, y_a, hs_a, vs_a, 1'b0};
      frozen_bad = 0;
      repeat (100) begin
         @(posedge clk); #1;
         if ({de_a, x_a, y_a, hs_a, vs_a, 1'b0} !== snap || ls_a !== 1'b0 || fs_a !== 1'b0)
            frozen_bad++;
      end
      check("freeze", frozen_bad, 0);
      strobe(1'b0);
      check("resume x", 32'(c_x), 301);
      check("resume y", 32'(c_y), 1);
      check("resume de", 32'(c_de), 1);

      // Reset mid-line with pclk high: reset wins on the next edge
      @(negedge clk);
      pclk_a = 1'b1;
      reset_a = 1'b0;
      @(posedge clk); #1;
      check("midrst outputs", {25'd0, hs_a, vs_a, de_a, x_a == 10'd0, y_a == 10'd0, ls_a, fs_a},
            {25'd0, 7'b1101100});
      @(negedge clk);
      pclk_a = 1'b0;
      reset_a = 1'b1;
      repeat (2) @(posedge clk);
      strobe(1'b0);
      check("midrst first fs", 32'(c_fs), 1);
      check("midrst first ls", 32'(c_ls), 1);
      check("midrst first xy", {c_de, 11'd0, c_x, c_y}, 32'h8000_0000);

      // pclk tied high on full-size instance: h_sync width and line period in clk
      begin
         int run, hs_w, ls_prev, ls_per;
         run = 0; hs_w = 0; ls_prev = -1; ls_per = 0;
         @(negedge clk);
         pclk_a = 1'b1;
         for (int c = 0; c < 1700; c++) begin
            @(posedge clk); #1;
            if (!hs_a) run++;
            else begin
               if (run > 0) hs_w = run;
               run = 0;
            end
            if (ls_a) begin
               if (ls_prev >= 0) ls_per = c - ls_prev;
               ls_prev = c;
            end
         end
         @(negedge clk);
         pclk_a = 1'b0;
         check("tied hsync width", hs_w, 96);
         check("tied line period", ls_per, 800);
      end

      // Shrunken instance: two frames at 1-in-4 strobes
      begin
         int fs_first, fs_second, sde, svs, svs_bad;
         fs_first = -1; fs_second = -1; sde = 0; svs = 0; svs_bad = 0;
         for (int kk = 1; kk <= 2 * S_FRAME + 1; kk++) begin
            strobe(1'b1);
            if (c_fs) begin
               if (fs_first < 0) fs_first = kk;
               else if (fs_second < 0) fs_second = kk;
            end
            if (kk <= S_FRAME) begin
               if (c_de) sde++;
               if (!c_vs) begin
                  svs++;
                  if (((kk - 1) / S_H_TOT) != 5 && ((kk - 1) / S_H_TOT) != 6) svs_bad++;
               end
            end
            if (kk == 3 * S_H_TOT + 8)
               check("small de edge", {c_de, 11'd0, c_x, c_y}, {1'b1, 11'd0, 10'd7, 10'd3});
            if (kk == 3 * S_H_TOT + 9)
               check("small de off", {c_de, 11'd0, c_x, c_y}, 32'd0);
         end
         check("small first fs", fs_first, 1);
         check("small frame strobes", fs_second - fs_first, S_FRAME);
         check("small de strobes", sde, S_H_ACT * S_V_ACT);
         check("small vsync strobes", svs, S_V_SYN * S_H_TOT);
         check("small vsync lines", svs_bad, 0);
      end

      // pclk tied high on shrunken instance: frame period and sync widths in clk
      begin
         int vrun, vs_w, hrun, hs_w, fs_prev, fs_per;
         vrun = 0; vs_w = 0; hrun = 0; hs_w = 0; fs_prev = -1; fs_per = 0;
         @(negedge clk);
         pclk_b = 1'b1;
         for (int c = 0; c < 3 * S_FRAME + 10; c++) begin
            @(posedge clk); #1;
            if (!vs_b) vrun++;
            else begin
               if (vrun > 0) vs_w = vrun;
               vrun = 0;
            end
            if (!hs_b) hrun++;
            else begin
               if (hrun > 0) hs_w = hrun;
               hrun = 0;
            end
            if (fs_b) begin
               if (fs_prev >= 0) fs_per = c - fs_prev;
               fs_prev = c;
            end
         end
         @(negedge clk);
         pclk_b = 1'b0;
         check("small tied frame period", fs_per, S_FRAME);
         check("small tied vsync width", vs_w, S_V_SYN * S_H_TOT);
         check("small tied hsync width", hs_w, S_H_SYN);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
